wts_tone_generator_nch: RTL
===========================

Name: wts_tone_generator_nch

Overview:
- Parametrised N-channel, time-multiplexed wave-table phase generator for the wave table sound engine.
- One shared phase-advance datapath serves all channels. The slot index `active` selects which per-channel counter/address pair is read, updated and written back each clock.
- New over the 5-channel generation:
  - channel count and counter widths are parameters;
  - per-channel one-shot (non-looping) playback with a done state;
  - registered, channel-tagged output stage.
- Sits between the register file (per-slot frequency/length/mode, muxed in by the slot sequencer) and the wave RAM read port.

Parameters:
- CH_NUM, 5: number of channels; legal 2..16.
- CH_BITS, 3: width of `active`; must satisfy 2**CH_BITS >= CH_NUM.
- FREQ_BITS, 12: width of the frequency divider counter.
- ADDR_BITS, 7: width of the wave address; maximum wave length is 2**ADDR_BITS samples.

Ports:
- nreset  in  1  asynchronous active-low reset
- clk  in  1  clock
- active  in  CH_BITS  current slot channel index; values >= CH_NUM are idle slots
- address_reset  in  1  zero counter and address of the active channel this slot
- reg_wave_length  in  2  active channel wave length: 0=32, 1=64, 2=128, 3=2**ADDR_BITS samples, each capped at 2**ADDR_BITS
- reg_frequency_count  in  FREQ_BITS  active channel period minus 1, in slots
- reg_wave_reset  in  1  when a clear hits, also zero the address
- reg_one_shot  in  1  active channel plays once and stops
- clear_counter  in  CH_NUM  per-channel key-on/restart strobe
- out_valid  out  1  wave_address/out_channel valid this cycle
- out_channel  out  CH_BITS  channel the outputs belong to
- wave_address  out  ADDR_BITS  updated wave address of out_channel
- half_timing  out  1  mid-period strobe for out_channel
- ch_done  out  CH_NUM  per-channel one-shot finished flag
- end_pulse  out  1  1-cycle strobe: out_channel just finished a one-shot

Behaviour:
- Reset: every channel has cnt=0, addr=0, state RUN. Outputs: out_valid=0, out_channel=0, wave_address=0, half_timing=0, ch_done=0, end_pulse=0.
- Per-channel state machine, RUN/DONE:
  - RUN->DONE when the active channel wraps with reg_one_shot=1.
  - DONE->RUN on clear_counter[k] or address_reset while active==k.
- Wave-length mask: M = (32<<reg_wave_length)-1, saturated to 2**ADDR_BITS-1.
- Update rule for active==k<CH_NUM, in priority order:
  1. clear_counter[k]: cnt<=0; addr<=0 if reg_wave_reset, else addr held; state<=RUN.
  2. address_reset: cnt<=0, addr<=0, state<=RUN.
  3. state DONE: no change.
  4. cnt==reg_frequency_count: cnt<=0 and address advances.
     - If (addr & M)==M (wrap) and reg_one_shot=1: addr stays M, state<=DONE, end_pulse asserted at output.
     - Otherwise: addr<=(addr+1)&M.
  5. Otherwise: cnt<=cnt+1.
- A cnt already above reg_frequency_count (frequency lowered mid-note) is treated as the terminal count: it advances and clears.
- reg_frequency_count=0: address advances every slot of that channel. Period = reg_frequency_count+1 slots.
- clear_counter[j] with j!=active is applied to channel j in the same cycle (rule 1 only). Multiple clear bits are handled simultaneously.
- half_timing=1 when the pre-update cnt == reg_frequency_count>>1 and state RUN; this includes reg_frequency_count=0.
- Output latency 1 clock: inputs sampled at edge t appear on out_* after edge t. wave_address is the post-update address. out_valid=1 for any active<CH_NUM slot.
- Idle slot (active>=CH_NUM): out_valid=0, half_timing=0, end_pulse=0; wave_address and out_channel hold.
- ch_done[k] mirrors state DONE and is registered with the same latency as the other outputs.
- Reset asserted mid-note aborts immediately; no partial state is retained.

Decomposition:
- Shared package `wts_pkg`:
  - wave-length code constants;
  - WTS_MIN_WAVE_LEN=32;
  - state encoding RUN=0, DONE=1.
- One natural sub-module, `wts_phase_step`: combinational next-cnt/next-addr/wrap/half logic for a single channel.
- Per-channel state is held in register arrays indexed by `active`, not in CH_NUM hand-written always blocks.

Test Plan:
- Loop, ch2, freq=3, len=0, slots cycling 0..4: addr of ch2 increments once per 4 ch2 slots and wraps 31->0. half_timing pulses when cnt==1.
- One-shot, ch0, freq=0, len=0: addr 0..31, then end_pulse=1 with addr=31. ch_done[0]=1; later ch0 slots keep addr=31 and produce no pulses.
- Restart: while ch0 DONE, pulse clear_counter[0] with reg_wave_reset=1 -> ch_done[0]=0 and addr restarts at 0. Repeat with reg_wave_reset=0 -> addr stays 31, cnt=0, state RUN.
- Same-cycle clear on the active channel, ch3 with cnt==freq -> clear wins: addr not advanced, cnt=0. Simultaneous clear_counter=5'b10011 -> ch0, ch1 and ch4 are all cleared.
- Idle slot with CH_NUM=5, active=6 or 7 -> out_valid=0; no channel state changes.
- Reset mid-note and parameter sweep: assert nreset low mid-playback -> all outputs 0 asynchronously. Re-run the loop test with CH_NUM=8, CH_BITS=3, ADDR_BITS=8, len=3 -> 256-sample wrap.

Source files
------------

// File: rtl/wts_pkg.sv
// Shared definitions for the wave table sound engine: wave-length codes,
// per-channel playback state and the wave-length mask helper.
package wts_pkg;

   localparam logic [1:0] WLEN_32  = 2'd0;
   localparam logic [1:0] WLEN_64  = 2'd1;
   localparam logic [1:0] WLEN_128 = 2'd2;
   localparam logic [1:0] WLEN_MAX = 2'd3;

   localparam int WTS_MIN_WAVE_LEN = 32;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } ch_state_t;

   // Address mask for a wave-length code, never wider than the address bus.
   function automatic logic [31:0] wave_mask(input logic [1:0] len_code, input int addr_bits);
      logic [31:0] m;
      case (len_code)
         WLEN_32:  m = 32'(WTS_MIN_WAVE_LEN) - 32'd1;
         WLEN_64:  m = (32'(WTS_MIN_WAVE_LEN) << 1) - 32'd1;
         WLEN_128: m = (32'(WTS_MIN_WAVE_LEN) << 2) - 32'd1;
         WLEN_MAX: m = 32'hFFFF_FFFF;
         default:  m = 32'hFFFF_FFFF;
      endcase
      return m & ((32'd1 << addr_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/wts_phase_step.sv
// Combinational phase advance for one channel: next counter/address,
// one-shot stop detection and mid-period strobe.
module wts_phase_step
   import wts_pkg::*;
#(
   parameter int FREQ_BITS = 12,
   parameter int ADDR_BITS = 7
) (
   input  logic [FREQ_BITS-1:0] cnt,
   input  logic [ADDR_BITS-1:0] addr,
   input  ch_state_t            state,
   input  logic [FREQ_BITS-1:0] frequency_count,
   input  logic [1:0]           wave_length,
   input  logic                 one_shot,
   output logic [FREQ_BITS-1:0] next_cnt,
   output logic [ADDR_BITS-1:0] next_addr,
   output logic                 stop,
   output logic                 half
);

   logic [ADDR_BITS-1:0] mask;
   logic                 terminal;
   logic                 wrap;

   assign mask     = ADDR_BITS'(wave_mask(wave_length, ADDR_BITS));
   // A count left above a freshly lowered period is treated as terminal.
   assign terminal = cnt >= frequency_count;
   assign wrap     = (addr & mask) == mask;
   assign half     = (state == ST_RUN) && (cnt == (frequency_count >> 1));

   always_comb begin
      next_cnt  = cnt;
      next_addr = addr;
      stop      = 1'b0;
      if (state == ST_RUN) begin
         if (terminal) begin
            next_cnt = '0;
            if (wrap && one_shot) begin
               next_addr = mask;
               stop      = 1'b1;
            end else begin
               next_addr = (addr + ADDR_BITS'(1)) & mask;
            end
         end else begin
            next_cnt = cnt + FREQ_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/wts_tone_generator_nch.sv
// N-channel time-multiplexed wave-table phase generator; one shared step
// datapath updates the channel selected by the current slot.
module wts_tone_generator_nch
   import wts_pkg::*;
#(
   parameter int CH_NUM    = 5,
   parameter int CH_BITS   = 3,
   parameter int FREQ_BITS = 12,
   parameter int ADDR_BITS = 7
) (
   input  logic                 nreset,
   input  logic                 clk,
   input  logic [CH_BITS-1:0]   active,
   input  logic                 address_reset,
   input  logic [1:0]           reg_wave_length,
   input  logic [FREQ_BITS-1:0] reg_frequency_count,
   input  logic                 reg_wave_reset,
   input  logic                 reg_one_shot,
   input  logic [CH_NUM-1:0]    clear_counter,
   output logic                 out_valid,
   output logic [CH_BITS-1:0]   out_channel,
   output logic [ADDR_BITS-1:0] wave_address,
   output logic                 half_timing,
   output logic [CH_NUM-1:0]    ch_done,
   output logic                 end_pulse
);

   logic [FREQ_BITS-1:0] cnt_q   [CH_NUM];
   logic [ADDR_BITS-1:0] addr_q  [CH_NUM];
   ch_state_t            state_q [CH_NUM];

   logic                 slot_ok;
   logic [CH_BITS-1:0]   slot;
   logic [FREQ_BITS-1:0] step_cnt;
   logic [ADDR_BITS-1:0] step_addr;
   logic                 step_stop;
   logic                 step_half;

   logic [FREQ_BITS-1:0] upd_cnt;
   logic [ADDR_BITS-1:0] upd_addr;
   ch_state_t            upd_state;
   logic                 upd_end;

   assign slot_ok = 32'(active) < CH_NUM;
   assign slot    = slot_ok ? active : '0;

   wts_phase_step #(
      .FREQ_BITS(FREQ_BITS),
      .ADDR_BITS(ADDR_BITS)
   ) u_step (
      .cnt             (cnt_q[slot]),
      .addr            (addr_q[slot]),
      .state           (state_q[slot]),
      .frequency_count (reg_frequency_count),
      .wave_length     (reg_wave_length),
      .one_shot        (reg_one_shot),
      .next_cnt        (step_cnt),
      .next_addr       (step_addr),
      .stop            (step_stop),
      .half            (step_half)
   );

   // Restart strobes override the regular advance of the active channel.
   always_comb begin
      upd_cnt   = step_cnt;
      upd_addr  = step_addr;
      upd_state = step_stop ? ST_DONE : state_q[slot];
      upd_end   = step_stop;
      if (clear_counter[slot]) begin
         upd_cnt   = '0;
         upd_addr  = reg_wave_reset ? '0 : addr_q[slot];
         upd_state = ST_RUN;
         upd_end   = 1'b0;
      end else if (address_reset) begin
         upd_cnt   = '0;
         upd_addr  = '0;
         upd_state = ST_RUN;
         upd_end   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int k = 0; k < CH_NUM; k++) begin
            cnt_q[k]   <= '0;
            addr_q[k]  <= '0;
            state_q[k] <= ST_RUN;
         end
         out_valid    <= 1'b0;
         out_channel  <= '0;
         wave_address <= '0;
         half_timing  <= 1'b0;
         end_pulse    <= 1'b0;
      end else begin
         for (int k = 0; k < CH_NUM; k++) begin
            if (slot_ok && (slot == CH_BITS'(k))) begin
               cnt_q[k]   <= upd_cnt;
               addr_q[k]  <= upd_addr;
               state_q[k] <= upd_state;
            end else if (clear_counter[k]) begin
               cnt_q[k]   <= '0;
               state_q[k] <= ST_RUN;
               if (reg_wave_reset) begin
                  addr_q[k] <= '0;
               end
            end
         end
         if (slot_ok) begin
            out_valid    <= 1'b1;
            out_channel  <= active;
            wave_address <= upd_addr;
            half_timing  <= step_half;
            end_pulse    <= upd_end;
         end else begin
            out_valid   <= 1'b0;
            half_timing <= 1'b0;
            end_pulse   <= 1'b0;
         end
      end
   end

   always_comb begin
      ch_done = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         ch_done[k] = (state_q[k] == ST_DONE);
      end
   end

endmodule
